// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
// Contents: parity_sel encodings, receiver FSM states, FIFO entry flag
// layout and the minimum legal baudrate.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BRK_WAIT
  } rx_state_e;

  // FIFO entry = {rx_flags_t, data[DATA_W-1:0]}
  typedef struct packed {
    logic brk;
    logic parity_err;
    logic frame_err;
  } rx_flags_t;

  localparam int unsigned ENTRY_FLAG_W = 3;
  localparam int unsigned BAUD_MIN     = 3;

  function automatic logic parity_enabled(input parity_e sel);
    return (sel == PAR_EVEN) || (sel == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive FIFO with level output
// Ports: clk_i/reset_i (sync, active high); push_i/wdata_i write side;
// pop_i/rdata_o/valid_o read side (head visible while valid_o);
// full_o and level_o report occupancy.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    count_q;
  logic             do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == LW'(DEPTH));
  assign do_pop  = pop_i && valid_o;
  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  // Head is forced to zero while empty so outputs read 0 after reset.
  assign rdata_o = valid_o ? mem_q[rptr_q] : '0;
  assign level_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - parametrised UART receiver with status-tagged FWFT FIFO
// Ports: mclk/reset (sync, active high); baudrate/parity_sel/stop_sel
// frame config, latched at each start edge; rx_en enable; rxd serial in;
// rd_en pops the head; rdata/rframe_err/rparity_err/rbreak/rvalid head
// entry; fifo_level occupancy; overrun sticky drop flag with clr_overrun;
// rx_busy FSM not idle.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned BAUD_W      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          mclk,
  input  logic                          reset,
  input  logic [BAUD_W-1:0]             baudrate,
  input  logic [1:0]                    parity_sel,
  input  logic                          stop_sel,
  input  logic                          rx_en,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rdata,
  output logic                          rframe_err,
  output logic                          rparity_err,
  output logic                          rbreak,
  output logic                          rvalid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  input  logic                          clr_overrun,
  output logic                          rx_busy
);

  localparam int unsigned EW    = DATA_W + ENTRY_FLAG_W;
  localparam int unsigned BIT_W = $clog2(DATA_W);

  // Input synchroniser and falling-edge detect; the detect is registered
  // so the FSM sees a clean one-cycle pulse.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q, fall_q, rxd_s;

  assign rxd_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge mclk) begin
    if (reset) begin
      sync_q <= '1;
      edge_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
      edge_q <= rxd_s;
      fall_q <= edge_q & ~rxd_s;
    end
  end

  rx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] cnt_q, cnt_d, baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_bit_q, par_bit_d;
  logic              stop_err_q, stop_err_d;
  parity_e           psel_q, psel_d;
  logic              stop2_q, stop2_d;
  logic              push_q, push_d;
  logic [EW-1:0]     entry_q, entry_d;
  logic              mid, bnd, par_err, is_break;

  assign mid = (cnt_q == (baud_q >> 1));
  assign bnd = (cnt_q == baud_q);
  assign par_err  = parity_enabled(psel_q) &&
                    ((^data_q ^ par_bit_q) != (psel_q == PAR_ODD));
  // Evaluated at the STOP1 sample: everything seen so far was low.
  assign is_break = (data_q == '0) && !rxd_s &&
                    (!parity_enabled(psel_q) || !par_bit_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = bnd ? '0 : cnt_q + 1'b1;
    bit_d      = bit_q;
    data_d     = data_q;
    par_bit_d  = par_bit_q;
    stop_err_d = stop_err_q;
    baud_d     = baud_q;
    psel_d     = psel_q;
    stop2_d    = stop2_q;
    push_d     = 1'b0;
    entry_d    = entry_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (fall_q && rx_en) begin
          baud_d  = (baudrate < BAUD_W'(BAUD_MIN)) ? BAUD_W'(BAUD_MIN) : baudrate;
          psel_d  = parity_e'(parity_sel);
          stop2_d = stop_sel;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (mid && rxd_s) begin
          state_d = ST_IDLE;
        end else if (bnd) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (mid) data_d = {rxd_s, data_q[DATA_W-1:1]};
        if (bnd) begin
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            state_d = parity_enabled(psel_q) ? ST_PARITY : ST_STOP1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (mid) par_bit_d = rxd_s;
        if (bnd) state_d = ST_STOP1;
      end
      ST_STOP1: begin
        if (mid) begin
          if (is_break) begin
            push_d  = 1'b1;
            entry_d = {1'b1, 1'b0, 1'b1, {DATA_W{1'b0}}};
            state_d = ST_BRK_WAIT;
          end else if (stop2_q) begin
            stop_err_d = ~rxd_s;
          end else begin
            push_d  = 1'b1;
            entry_d = {1'b0, par_err, ~rxd_s, data_q};
            state_d = ST_IDLE;
          end
        end else if (bnd) begin
          state_d = ST_STOP2;
        end
      end
      ST_STOP2: begin
        if (mid) begin
          push_d  = 1'b1;
          entry_d = {1'b0, par_err, stop_err_q | ~rxd_s, data_q};
          state_d = ST_IDLE;
        end
      end
      ST_BRK_WAIT: begin
        if (rxd_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Disabling the receiver drops whatever frame is in progress.
    if (!rx_en) begin
      state_d = ST_IDLE;
      push_d  = 1'b0;
    end
    if (state_d == ST_IDLE || state_d == ST_BRK_WAIT) cnt_d = '0;
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      par_bit_q  <= 1'b0;
      stop_err_q <= 1'b0;
      baud_q     <= BAUD_W'(BAUD_MIN);
      psel_q     <= PAR_NONE;
      stop2_q    <= 1'b0;
      push_q     <= 1'b0;
      entry_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      par_bit_q  <= par_bit_d;
      stop_err_q <= stop_err_d;
      baud_q     <= baud_d;
      psel_q     <= psel_d;
      stop2_q    <= stop2_d;
      push_q     <= push_d;
      entry_q    <= entry_d;
    end
  end

  logic [EW-1:0] fifo_rd;
  logic          fifo_full, overrun_q;
  rx_flags_t     head_flags;

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (mclk),
    .reset_i (reset),
    .push_i  (push_q),
    .wdata_i (entry_q),
    .pop_i   (rd_en),
    .rdata_o (fifo_rd),
    .valid_o (rvalid),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  // A write into a full FIFO is lost unless the head leaves in the same cycle.
  always_ff @(posedge mclk) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (push_q && fifo_full && !rd_en) begin
      overrun_q <= 1'b1;
    end else if (clr_overrun) begin
      overrun_q <= 1'b0;
    end
  end

  assign head_flags  = fifo_rd[EW-1:DATA_W];
  assign rdata       = fifo_rd[DATA_W-1:0];
  assign rframe_err  = head_flags.frame_err;
  assign rparity_err = head_flags.parity_err;
  assign rbreak      = head_flags.brk;
  assign overrun     = overrun_q;
  assign rx_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed table-driven bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  localparam int BIT_CYC = 16;

  logic        mclk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] baudrate = 16'd15;
  logic [1:0]  parity_sel = 2'b00;
  logic        stop_sel = 1'b0;
  logic        rx_en = 1'b1;
  logic        rxd = 1'b1;
  logic        rd_en = 1'b0;
  logic        clr_overrun = 1'b0;
  logic [7:0]  rdata;
  logic        rframe_err, rparity_err, rbreak, rvalid, overrun, rx_busy;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;
  int lat_busy, lat_valid, mon_n;

  uart_rx_ctrl #(
    .DATA_W(8), .FIFO_DEPTH(4), .BAUD_W(16), .SYNC_STAGES(2)
  ) dut (
    .mclk(mclk), .reset(reset), .baudrate(baudrate), .parity_sel(parity_sel),
    .stop_sel(stop_sel), .rx_en(rx_en), .rxd(rxd), .rd_en(rd_en),
    .rdata(rdata), .rframe_err(rframe_err), .rparity_err(rparity_err),
    .rbreak(rbreak), .rvalid(rvalid), .fifo_level(fifo_level),
    .overrun(overrun), .clr_overrun(clr_overrun), .rx_busy(rx_busy)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic [7:0] d;
    logic [1:0] psel;
    logic       two;
    logic       badp;
    logic       s1;
    logic       s2;
    logic [7:0] ed;
    logic       ef;
    logic       ep;
  } vec_t;

  vec_t vecs[7];

  task automatic tick(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] psel,
                            input logic two, input logic badp,
                            input logic s1, input logic s2);
    parity_sel = psel;
    stop_sel   = two;
    rxd = 1'b0;
    tick(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      tick(BIT_CYC);
    end
    if (psel == 2'b01 || psel == 2'b10) begin
      rxd = (^d) ^ (psel == 2'b10) ^ badp;
      tick(BIT_CYC);
    end
    rxd = s1;
    tick(BIT_CYC);
    if (two) begin
      rxd = s2;
      tick(BIT_CYC);
    end
    rxd = 1'b1;
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    chk(name, rdata, exp);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h35, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 8'h35, 1'b0, 1'b1};
    vecs[1] = '{8'h35, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 8'h35, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'h5A, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0};

    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_flags", {rframe_err, rparity_err, rbreak}, 0);

    // 8N1 0xA5 with busy and rvalid latency from the start-bit edge
    lat_busy = -1;
    lat_valid = -1;
    fork
      send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        mon_n = 0;
        while (mon_n < 400 && lat_valid < 0) begin
          @(posedge mclk);
          #1;
          mon_n++;
          if (rx_busy && lat_busy < 0) lat_busy = mon_n;
          if (rvalid) lat_valid = mon_n;
        end
      end
    join
    chk("busy_latency", lat_busy, 4);
    chk("rvalid_latency", lat_valid, 157);
    chk("a5_flags", {rframe_err, rparity_err, rbreak}, 0);
    chk("a5_level", fifo_level, 1);
    pop_check("a5_data", 8'hA5);
    chk("a5_empty", rvalid, 0);

    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].d, vecs[v].psel, vecs[v].two, vecs[v].badp, vecs[v].s1, vecs[v].s2);
      tick(4);
      chk($sformatf("v%0d_rvalid", v), rvalid, 1);
      chk($sformatf("v%0d_level", v), fifo_level, 1);
      chk($sformatf("v%0d_frame", v), rframe_err, vecs[v].ef);
      chk($sformatf("v%0d_parity", v), rparity_err, vecs[v].ep);
      chk($sformatf("v%0d_break", v), rbreak, 0);
      pop_check($sformatf("v%0d_data", v), vecs[v].ed);
      chk($sformatf("v%0d_pop_level", v), fifo_level, 0);
    end

    // false start: 4-cycle low glitch
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    chk("glitch_busy_hi", rx_busy, 1);
    tick(30);
    chk("glitch_busy_lo", rx_busy, 0);
    chk("glitch_level", fifo_level, 0);

    // break: 8E1, line low for three frame times
    parity_sel = 2'b01;
    stop_sel = 1'b0;
    rxd = 1'b0;
    tick(3 * 11 * BIT_CYC);
    chk("brk_level", fifo_level, 1);
    chk("brk_data", rdata, 0);
    chk("brk_flags", {rbreak, rframe_err, rparity_err}, 3'b110);
    chk("brk_busy", rx_busy, 1);
    rxd = 1'b1;
    tick(8);
    chk("brk_exit_busy", rx_busy, 0);
    pop_check("brk_pop", 8'h00);
    send_frame(8'h3C, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(4);
    chk("post_brk_flags", {rbreak, rframe_err, rparity_err}, 0);
    pop_check("post_brk_data", 8'h3C);

    // config changed mid-frame must not affect the frame in flight
    fork
      send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        tick(40);
        baudrate = 16'd7;
        parity_sel = 2'b01;
        stop_sel = 1'b1;
      end
    join
    tick(4);
    chk("cfg_level", fifo_level, 1);
    chk("cfg_flags", {rbreak, rframe_err, rparity_err}, 0);
    pop_check("cfg_data", 8'hA5);
    baudrate = 16'd15;

    // rx_en abort discards the partial frame
    fork
      send_frame(8'hC3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        tick(60);
        rx_en = 1'b0;
        tick(1);
        chk("abort_busy", rx_busy, 0);
      end
    join
    tick(4);
    rx_en = 1'b1;
    chk("abort_level", fifo_level, 0);

    // overrun: five frames into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i * 8'h11), 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    tick(4);
    chk("ovr_level", fifo_level, 4);
    chk("ovr_flag", overrun, 1);
    for (int i = 1; i <= 4; i++) pop_check($sformatf("ovr_data%0d", i), 8'(i * 8'h11));
    chk("ovr_drained", fifo_level, 0);
    chk("ovr_sticky", overrun, 1);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    chk("ovr_cleared", overrun, 0);

    // write into full FIFO with coincident pop
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(8'h60 + i), 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    tick(4);
    chk("full_level", fifo_level, 4);
    fork
      send_frame(8'h65, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        tick(156);
        chk("coinc_pre_level", fifo_level, 4);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        chk("coinc_level", fifo_level, 4);
        chk("coinc_overrun", overrun, 0);
      end
    join
    for (int i = 2; i <= 5; i++) pop_check($sformatf("coinc_data%0d", i), 8'(8'h60 + i));

    // reset mid-frame with FIFO full and overrun set
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(8'h70 + i), 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    tick(4);
    chk("pre_rst_overrun", overrun, 1);
    fork
      send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        tick(50);
        chk("pre_rst_busy", rx_busy, 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_busy", rx_busy, 0);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_flags", {rframe_err, rparity_err, rbreak}, 0);
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
